// File: rtl/keypad_digit_bus_if.sv
// Keypad entry bus: key strobes in, live entry and
// committed value out with a valid/ready handshake.
interface keypad_digit_bus_if #(
  parameter int NDIG = 4,
  parameter int DW   = 4
);
  localparam int W  = NDIG * DW;
  localparam int CW = $clog2(NDIG + 1);

  logic          key_valid;
  logic [DW-1:0] key_code;
  logic          key_back;
  logic          key_clear;
  logic          commit;
  logic          out_ready;
  logic [W-1:0]  entry_bus;
  logic [CW-1:0] digit_count;
  logic          full;
  logic [W-1:0]  out_bus;
  logic          out_valid;
  logic          err;

  modport master (
    output key_valid, key_code, key_back,
    output key_clear, commit, out_ready,
    input  entry_bus, digit_count, full,
    input  out_bus, out_valid, err
  );

  modport slave (
    input  key_valid, key_code, key_back,
    input  key_clear, commit, out_ready,
    output entry_bus, digit_count, full,
    output out_bus, out_valid, err
  );
endinterface

// File: rtl/keypad_digit_bus.sv
// Packs keypad digits into a shift register and
// publishes the entry on commit until it is consumed.
module keypad_digit_bus #(
  parameter int NDIG      = 4,
  parameter int DW        = 4,
  parameter int RADIX     = 10,
  parameter int OVF_SHIFT = 1
) (
  input logic               clk,
  input logic               rst_n,
  keypad_digit_bus_if.slave bus
);
  localparam int W  = NDIG * DW;
  localparam int CW = $clog2(NDIG + 1);
  localparam logic [DW:0] RAD = RADIX[DW:0];

  typedef enum logic {EDIT, HOLD} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  entry_q, entry_d;
  logic [W-1:0]  out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovalid_q, ovalid_d;
  logic          err_q, err_d;

  logic          code_ok;
  logic          is_full;
  logic [W-1:0]  ins;

  assign code_ok = {1'b0, bus.key_code} < RAD;
  assign is_full = cnt_q == CW'(NDIG);
  // Shifting left drops digit NDIG-1 for free.
  assign ins = (entry_q << DW) | W'(bus.key_code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EDIT;
      entry_q  <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      ovalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      ovalid_q <= ovalid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    ovalid_d = ovalid_q;
    err_d    = 1'b0;
    unique case (state_q)
      EDIT: begin
        if (bus.key_clear) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (bus.commit) begin
          out_d    = entry_q;
          ovalid_d = 1'b1;
          entry_d  = '0;
          cnt_d    = '0;
          state_d  = HOLD;
        end else if (bus.key_back) begin
          if (cnt_q != '0) begin
            entry_d = entry_q >> DW;
            cnt_d   = cnt_q - CW'(1);
          end
        end else if (bus.key_valid) begin
          if (!code_ok) begin
            err_d = 1'b1;
          end else if (!is_full) begin
            entry_d = ins;
            cnt_d   = cnt_q + CW'(1);
          end else if (OVF_SHIFT != 0) begin
            entry_d = ins;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.key_clear) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (bus.commit) begin
          err_d = 1'b1;
        end
        if (bus.out_ready) begin
          ovalid_d = 1'b0;
          state_d  = EDIT;
        end
      end
      default: ;
    endcase
  end

  assign bus.entry_bus   = entry_q;
  assign bus.digit_count = cnt_q;
  assign bus.full        = is_full;
  assign bus.out_bus     = out_q;
  assign bus.out_valid   = ovalid_q;
  assign bus.err         = err_q;
endmodule

// File: doc/keypad_digit_bus.md
KEYPAD_DIGIT_BUS -- requirements
Module: keypad_digit_bus

Interface
REQ-001 SHALL have parameter NDIG, default 4, number of packed digits (1..8).
REQ-002 SHALL have parameter DW, default 4, bits per digit.
REQ-003 SHALL have parameter RADIX, default 10, accepted codes 0..RADIX-1 (RADIX <= 2**DW).
REQ-004 SHALL have parameter OVF_SHIFT, default 1; 1 = drop oldest digit when full, 0 = reject new digit when full.
REQ-005 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock, all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 key_valid  input  1  one-cycle strobe, key_code valid.
REQ-009 key_code  input  DW  digit code from keypad.
REQ-010 key_back  input  1  one-cycle strobe, delete newest digit.
REQ-011 key_clear  input  1  one-cycle strobe, clear entry.
REQ-012 commit  input  1  one-cycle strobe, publish entry to out_bus.
REQ-013 out_ready  input  1  consumer accepts out_bus.
REQ-014 entry_bus  output  NDIG*DW  live entry; digit i at bits [i*DW +: DW]; digit 0 (newest) in LSBs.
REQ-015 digit_count  output  $clog2(NDIG+1)  digits entered.
REQ-016 full  output  1  digit_count == NDIG.
REQ-017 out_bus  output  NDIG*DW  committed value, same packing as entry_bus.
REQ-018 out_valid  output  1  out_bus valid, held until out_ready.
REQ-019 err  output  1  one-cycle pulse on rejected event.

Function
REQ-020 SHALL implement two states: EDIT and HOLD; the state is internal.
REQ-021 SHALL update all outputs from registers only; an event sampled at edge k is visible after edge k (1-cycle latency).
REQ-022 SHALL apply per-cycle priority in EDIT: key_clear > commit > key_back > key_valid; lower-priority events in the same cycle are dropped, and err is not pulsed for them.
REQ-023 key_clear: entry_bus <= 0 and digit_count <= 0 in either state; state is unchanged.
REQ-024 commit in EDIT: out_bus <= entry_bus, out_valid <= 1, entry_bus <= 0, digit_count <= 0, state <= HOLD; a commit with digit_count 0 publishes zero.
REQ-025 key_back: shift entry right by DW, top digit <= 0, digit_count - 1; no-op without err when digit_count == 0.
REQ-026 key_valid with key_code < RADIX and not full: shift entry left by DW, digit 0 <= key_code, digit_count + 1.
REQ-027 key_valid when full with OVF_SHIFT=1: shift left, discard digit NDIG-1, digit 0 <= key_code; digit_count stays NDIG.
REQ-028 key_valid when full with OVF_SHIFT=0: entry unchanged; err pulses.
REQ-029 key_valid with key_code >= RADIX: entry unchanged; err pulses.
REQ-030 In HOLD, key_clear is the only entry event honoured; key_valid, key_back and commit are ignored, and commit additionally pulses err.
REQ-031 In HOLD, out_bus and out_valid SHALL remain stable until out_ready is sampled high.
REQ-032 out_valid && out_ready at edge: out_valid <= 0, state <= EDIT; out_bus retains its value; events in that cycle are processed per HOLD rules.
REQ-033 full SHALL equal (digit_count == NDIG) every cycle.

Reset
REQ-034 rst_n low SHALL immediately force: state EDIT, entry_bus 0, digit_count 0, out_bus 0, out_valid 0, err 0, with no clock required.
REQ-035 Reset asserted mid-HOLD SHALL discard the pending out_bus.
REQ-036 After rst_n deasserts, the first event SHALL be honoured on the first rising edge with rst_n high.

Verification
REQ-037 Defaults: keys 1,2,3 -> entry_bus 16'h0123, digit_count 3, full 0.
REQ-038 Keys 1,2,3,4,5 with OVF_SHIFT=1 -> 16'h2345, full 1; with OVF_SHIFT=0 -> 16'h1234 plus one err pulse.
REQ-039 Entry 16'h0123, key_back -> 16'h0012, count 2; key_code 4'hB -> err pulse, entry unchanged.
REQ-040 Entry 16'h0012, commit with out_ready 0 for 3 cycles -> out_bus 16'h0012 and out_valid held; keys ignored; second commit -> err; out_ready 1 -> out_valid 0 next cycle.
REQ-041 key_clear, commit and key_valid in the same cycle -> entry 0, no commit, out_valid 0.
REQ-042 rst_n pulsed low mid-HOLD between clock edges -> all outputs 0 immediately.
